alif_layer: RTL and testbench
=============================

# alif_layer

Parametrised layer of adaptive leaky integrate-and-fire neurons, the multi-channel successor to the single-neuron ALIF core. Each channel has its own registered membrane potential, adaptive threshold offset and refractory counter, with configurable leak, threshold decay and refractory period. All channels update together on a tick strobe. The layer sits between the input current pins or an upstream current generator and the spike/state outputs of the top-level wrapper.

## Interface
- CHANNELS, 4: number of independent neurons
- WIDTH, 8: width of current, membrane and threshold values (unsigned)
- BASE_THRESHOLD, 120: resting firing threshold
- ADAPT_STEP, 20: threshold increment per spike
- ADAPT_DECAY_SHIFT, 3: adaptation decays by A>>shift per non-spiking tick
- LEAK_SHIFT, 4: membrane leaks by V>>shift per tick; 0 disables leak
- REFRACTORY, 2: ticks held at reset after a spike; 0 disables
- RESET_VALUE, 0: membrane value after reset or spike
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  tick strobe; in_current sampled when high
- in_current  in  CHANNELS*WIDTH  per-channel current; channel i at bits [i*WIDTH +: WIDTH]
- out_valid  out  1  one-cycle pulse, one cycle after each accepted tick
- spike  out  CHANNELS  per-channel spike, qualified by out_valid
- state  out  CHANNELS*WIDTH  per-channel membrane potential, same packing as in_current
- spike_any  out  1  OR of spike, qualified by out_valid

## Operation
Per channel i, on a cycle with in_valid=1 (a tick), with registered V, A and R:
- If R>0: V<=RESET_VALUE, R<=R-1, A held, no spike.
- Else compute sum = V - (V>>LEAK_SHIFT) + I in WIDTH+1 bits. Saturate it to 2^WIDTH-1 to give Vn.
- T = min(BASE_THRESHOLD + A, 2^WIDTH-1), computed in WIDTH+1 bits. Use A before the update.
- If Vn >= T: spike, V<=RESET_VALUE, A<=min(A+ADAPT_STEP, 2^WIDTH-1-BASE_THRESHOLD), R<=REFRACTORY.
- Else: V<=Vn, no spike. If A>0, A<=A-max(A>>ADAPT_DECAY_SHIFT,1).
- Cycles with in_valid=0: all state held, out_valid=0, spike=0, spike_any=0.
- No back-pressure. A tick is accepted every cycle in_valid is high, including back-to-back ticks.
- Channels are fully independent. There is no lateral inhibition.

## Timing
- Reset (rst=1 at a clock edge) sets V=RESET_VALUE, A=0, R=0, out_valid=0, spike=0, spike_any=0, state=RESET_VALUE on every channel.
- rst overrides a coincident in_valid. That tick is discarded.
- Reset mid-refractory clears R. The next tick integrates normally.
- Latency is 1: out_valid, spike and spike_any are registered and assert the cycle after the tick edge.
- state reflects V updated by the same tick.
- spike is 0 whenever out_valid is 0.
- Back-to-back ticks produce back-to-back out_valid pulses.
- Boundary conditions:
  - Saturation: Vn clamps at 2^WIDTH-1, and T clamps at 2^WIDTH-1. A neuron at saturated V with saturated T still fires.
  - A never exceeds 2^WIDTH-1-BASE_THRESHOLD.
  - R width is clog2(REFRACTORY+1), minimum 1 bit.

## Structure
- Package alif_pkg holds the shared defaults (BASE_THRESHOLD, ADAPT_STEP, decay/leak shifts, REFRACTORY, RESET_VALUE). It also holds a saturating-add function used by both the membrane and threshold paths.
- Sub-module alif_cell is one neuron: V/A/R registers and the update logic, with ports tick, current, spike_next, V.
- alif_layer instantiates CHANNELS alif_cell in a generate loop. It registers out_valid, spike and spike_any.

## Test plan
- Constant current 50 on ch0, defaults (leak 4), ticks every cycle:
  - State goes 50, 97.
  - Third tick gives spike[0]=1, state 0. Checks 97-6+50=141 >= 120.
  - Next two out_valid pulses have spike 0, state 0 (refractory).
- Adaptation, continuing ch0 at current 50:
  - Post-refractory A decays 20→18→16 over the next two non-spiking ticks.
  - Third tick, V=141, T=136: spike. A becomes 36.
- Current 255 on all channels, one tick:
  - All spikes 1, spike_any=1, states 0 (saturation path).
  - Other channels at current 0 stay 0.
- Gapped ticks: in_valid high every 3rd cycle:
  - out_valid pulses exactly 1 cycle after each tick.
  - spike and state hold with no change between ticks.
- rst asserted during ch0 refractory, coincident with in_valid:
  - All outputs 0 next cycle, tick discarded.
  - Next tick with current 50 gives state 50, no spike.
- Threshold ceiling: sustained current 255 for many ticks:
  - A clamps at 135.
  - Neuron still spikes once every REFRACTORY+1 ticks.

Source files
------------

// File: rtl/alif_pkg.sv
// rtl/alif_pkg.sv - shared defaults and saturating arithmetic for the ALIF layer
package alif_pkg;

  localparam int DEF_CHANNELS          = 4;
  localparam int DEF_WIDTH             = 8;
  localparam int DEF_BASE_THRESHOLD    = 120;
  localparam int DEF_ADAPT_STEP        = 20;
  localparam int DEF_ADAPT_DECAY_SHIFT = 3;
  localparam int DEF_LEAK_SHIFT        = 4;
  localparam int DEF_REFRACTORY        = 2;
  localparam int DEF_RESET_VALUE       = 0;

  // Operands are small non-negative values, so 32-bit headroom never overflows.
  function automatic int sat_add(input int a, input int b, input int max_val);
    int s;
    s = a + b;
    return (s > max_val) ? max_val : s;
  endfunction

endpackage

// File: rtl/alif_cell.sv
// rtl/alif_cell.sv - one adaptive leaky integrate-and-fire neuron
module alif_cell
  import alif_pkg::*;
#(
  parameter int WIDTH             = DEF_WIDTH,
  parameter int BASE_THRESHOLD    = DEF_BASE_THRESHOLD,
  parameter int ADAPT_STEP        = DEF_ADAPT_STEP,
  parameter int ADAPT_DECAY_SHIFT = DEF_ADAPT_DECAY_SHIFT,
  parameter int LEAK_SHIFT        = DEF_LEAK_SHIFT,
  parameter int REFRACTORY        = DEF_REFRACTORY,
  parameter int RESET_VALUE       = DEF_RESET_VALUE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic [WIDTH-1:0] current,
  output logic             spike_next,
  output logic [WIDTH-1:0] V
);

  localparam int MAXV  = (1 << WIDTH) - 1;
  localparam int AMAX  = MAXV - BASE_THRESHOLD;
  localparam int RW_CL = $clog2(REFRACTORY + 1);
  localparam int RW    = (RW_CL < 1) ? 1 : RW_CL;

  logic [WIDTH-1:0] v_q;
  logic [WIDTH-1:0] a_q;
  logic [RW-1:0]    r_q;

  logic [WIDTH-1:0] leak;
  logic [WIDTH-1:0] vn;
  logic [31:0]      thr;
  logic             fire;
  logic [WIDTH-1:0] a_inc;
  logic [WIDTH-1:0] decay;
  logic [WIDTH-1:0] a_dec;

  always_comb begin
    leak       = '0;
    vn         = '0;
    thr        = '0;
    fire       = 1'b0;
    a_inc      = '0;
    decay      = '0;
    a_dec      = '0;
    spike_next = 1'b0;

    if (LEAK_SHIFT != 0) leak = v_q >> LEAK_SHIFT;
    // leak never exceeds v_q, so the subtraction cannot wrap
    vn    = WIDTH'(sat_add(32'(v_q - leak), 32'(current), MAXV));
    // threshold uses the adaptation value from before this tick
    thr   = 32'(sat_add(BASE_THRESHOLD, 32'(a_q), MAXV));
    fire  = (r_q == '0) && (32'(vn) >= thr);
    a_inc = WIDTH'(sat_add(32'(a_q), ADAPT_STEP, AMAX));
    decay = a_q >> ADAPT_DECAY_SHIFT;
    if (decay == '0) decay = WIDTH'(1);
    a_dec = (a_q == '0) ? '0 : a_q - decay;
    spike_next = tick & fire;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= WIDTH'(RESET_VALUE);
      a_q <= '0;
      r_q <= '0;
    end else if (tick) begin
      if (r_q != '0) begin
        v_q <= WIDTH'(RESET_VALUE);
        r_q <= r_q - RW'(1);
      end else if (fire) begin
        v_q <= WIDTH'(RESET_VALUE);
        a_q <= a_inc;
        r_q <= RW'(REFRACTORY);
      end else begin
        v_q <= vn;
        a_q <= a_dec;
      end
    end
  end

  assign V = v_q;

endmodule

// File: rtl/alif_layer.sv
// rtl/alif_layer.sv - parallel layer of ALIF neurons updated on a common tick
module alif_layer
  import alif_pkg::*;
#(
  parameter int CHANNELS          = DEF_CHANNELS,
  parameter int WIDTH             = DEF_WIDTH,
  parameter int BASE_THRESHOLD    = DEF_BASE_THRESHOLD,
  parameter int ADAPT_STEP        = DEF_ADAPT_STEP,
  parameter int ADAPT_DECAY_SHIFT = DEF_ADAPT_DECAY_SHIFT,
  parameter int LEAK_SHIFT        = DEF_LEAK_SHIFT,
  parameter int REFRACTORY        = DEF_REFRACTORY,
  parameter int RESET_VALUE       = DEF_RESET_VALUE
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [CHANNELS*WIDTH-1:0] in_current,
  output logic                      out_valid,
  output logic [CHANNELS-1:0]       spike,
  output logic [CHANNELS*WIDTH-1:0] state,
  output logic                      spike_any
);

  logic [CHANNELS-1:0] spike_d;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_cell
    alif_cell #(
      .WIDTH            (WIDTH),
      .BASE_THRESHOLD   (BASE_THRESHOLD),
      .ADAPT_STEP       (ADAPT_STEP),
      .ADAPT_DECAY_SHIFT(ADAPT_DECAY_SHIFT),
      .LEAK_SHIFT       (LEAK_SHIFT),
      .REFRACTORY       (REFRACTORY),
      .RESET_VALUE      (RESET_VALUE)
    ) u_cell (
      .clk       (clk),
      .rst       (rst),
      .tick      (in_valid),
      .current   (in_current[i*WIDTH +: WIDTH]),
      .spike_next(spike_d[i]),
      .V         (state[i*WIDTH +: WIDTH])
    );
  end

  // spike_d is already gated by the tick, so idle cycles register zeros
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      spike     <= '0;
      spike_any <= 1'b0;
    end else begin
      out_valid <= in_valid;
      spike     <= spike_d;
      spike_any <= |spike_d;
    end
  end

endmodule

// File: tb/tb_alif_layer.sv
// tb/tb_alif_layer.sv - directed self-checking bench for alif_layer
module tb_alif_layer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_current = '0;
  logic        out_valid;
  logic [3:0]  spike;
  logic [31:0] state;
  logic        spike_any;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alif_layer u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_current(in_current),
    .out_valid (out_valid),
    .spike     (spike),
    .state     (state),
    .spike_any (spike_any)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic [31:0] cur);
    in_valid   = v;
    in_current = cur;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic ov, input logic [3:0] sp, input logic [31:0] st);
    chk({tag, "_valid"}, 32'(out_valid), 32'(ov));
    chk({tag, "_spike"}, 32'(spike), 32'(sp));
    chk({tag, "_any"}, 32'(spike_any), 32'(|sp));
    chk({tag, "_state"}, state, st);
  endtask

  logic [7:0] exp_st [8];
  logic [3:0] exp_sp [8];

  initial begin
    // reset state
    do_reset();
    chk_out("reset", 1'b0, 4'h0, 32'h0);

    // ch0 integrate, fire, refractory, adaptation
    exp_st = '{8'd50, 8'd97, 8'd0, 8'd0, 8'd0, 8'd50, 8'd97, 8'd0};
    exp_sp = '{4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1};
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 32'd50);
      chk_out($sformatf("ch0_tick%0d", k + 1), 1'b1, exp_sp[k], {24'h0, exp_st[k]});
    end
    step(1'b0, 32'd50);
    chk_out("idle_after_ch0", 1'b0, 4'h0, 32'h0);

    // reset while ch0 refractory and a tick is offered
    rst = 1'b1;
    step(1'b1, 32'd50);
    rst = 1'b0;
    chk_out("rst_tick", 1'b0, 4'h0, 32'h0);
    step(1'b1, 32'd50);
    chk_out("post_rst", 1'b1, 4'h0, 32'd50);

    // saturation on all channels
    do_reset();
    step(1'b1, 32'hFFFF_FFFF);
    chk_out("sat_all", 1'b1, 4'hF, 32'h0);

    // one saturated channel, others idle at zero current
    do_reset();
    step(1'b1, 32'h0000_FF00);
    chk_out("sat_ch1", 1'b1, 4'h2, 32'h0);

    // gapped ticks on ch2 with current 30: 30, 59, 86
    do_reset();
    step(1'b1, 32'h001E_0000);
    chk_out("gap_t1", 1'b1, 4'h0, 32'h001E_0000);
    step(1'b0, 32'h001E_0000);
    chk_out("gap_h1a", 1'b0, 4'h0, 32'h001E_0000);
    step(1'b0, 32'h001E_0000);
    chk_out("gap_h1b", 1'b0, 4'h0, 32'h001E_0000);
    step(1'b1, 32'h001E_0000);
    chk_out("gap_t2", 1'b1, 4'h0, 32'h003B_0000);
    step(1'b0, 32'h001E_0000);
    chk_out("gap_h2a", 1'b0, 4'h0, 32'h003B_0000);
    step(1'b0, 32'h001E_0000);
    chk_out("gap_h2b", 1'b0, 4'h0, 32'h003B_0000);
    step(1'b1, 32'h001E_0000);
    chk_out("gap_t3", 1'b1, 4'h0, 32'h0056_0000);

    // sustained 255 on ch3: fires every third tick, adaptation clamps at 135
    do_reset();
    for (int k = 0; k < 30; k++) begin
      step(1'b1, 32'hFF00_0000);
      chk_out($sformatf("ceil_tick%0d", k + 1), 1'b1, (k % 3 == 0) ? 4'h8 : 4'h0, 32'h0);
    end
    chk("ceil_adapt", 32'(u_dut.g_cell[3].u_cell.a_q), 32'd135);
    step(1'b0, 32'h0);
    chk_out("ceil_idle", 1'b0, 4'h0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
